// File: rtl/matrix_frame_ctrl.sv
// Double-buffered 5x5 frame store with frame-aligned bank swap and frame-rate blink.
// Row outputs are registered: one cycle after any bank, select or phase change.
module matrix_frame_ctrl #(
    parameter int ROW_CYCLES   = 1000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic       PIXEL_CLK,
    input  logic       RESET,
    input  logic       I_wr_en,
    input  logic [2:0] I_wr_row,
    input  logic [4:0] I_wr_data,
    input  logic       I_swap_req,
    output logic       O_swap_ack,
    input  logic       I_blink_en,
    output logic       O_frame_tick,
    output logic       O_wr_err,
    output logic [4:0] O_row0,
    output logic [4:0] O_row1,
    output logic [4:0] O_row2,
    output logic [4:0] O_row3,
    output logic [4:0] O_row4
);

    localparam int FRAME_CYCLES = 5 * ROW_CYCLES;
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(FRAME_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_WAIT_DROP} swap_state_t;
    typedef enum logic {PH_VISIBLE, PH_HIDDEN} phase_t;

    swap_state_t            state_q, state_d;
    phase_t                 phase_q, phase_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   fb_q, fb_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    // bank_q[fb_q] is the displayed bank; bank_q[~fb_q] is the producer's back bank.
    logic [1:0][4:0][4:0]   bank_q, bank_d;
    logic [4:0][4:0]        row_q, row_d;
    logic                   tick;
    logic                   visible;

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge PIXEL_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_VISIBLE;
            cnt_q       <= '0;
            blink_cnt_q <= '0;
            fb_q        <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            bank_q      <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            blink_cnt_q <= blink_cnt_d;
            fb_q        <= fb_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
        end
    end

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        state_d     = state_q;
        fb_d        = fb_q;
        ack_d       = 1'b0;
        bank_d      = bank_q;
        err_d       = I_wr_en && (I_wr_row > 3'd4);
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        // Back-bank write uses the pre-swap select, so a write on the swap edge becomes visible.
        if (I_wr_en && (I_wr_row <= 3'd4))
            bank_d[~fb_q][I_wr_row] = I_wr_data;

        case (state_q)
            S_IDLE:      if (I_swap_req) state_d = S_PENDING;
            S_PENDING: begin
                if (tick) begin
                    fb_d    = ~fb_q;
                    ack_d   = 1'b1;
                    state_d = S_WAIT_DROP;
                end
            end
            S_WAIT_DROP: if (!I_swap_req) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        if (!I_blink_en) begin
            blink_cnt_d = '0;
            phase_d     = PH_VISIBLE;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // Dropping blink enable unblanks on the very next output update.
        visible = !I_blink_en || (phase_q == PH_VISIBLE);
        row_d   = visible ? bank_q[fb_q] : '0;
    end

    assign O_frame_tick = tick;
    assign O_swap_ack   = ack_q;
    assign O_wr_err     = err_q;
    assign O_row0       = row_q[0];
    assign O_row1       = row_q[1];
    assign O_row2       = row_q[2];
    assign O_row3       = row_q[3];
    assign O_row4       = row_q[4];

endmodule

// File: tb/tb_matrix_frame_ctrl.sv
// Directed bench for matrix_frame_ctrl with ROW_CYCLES=4 (20-cycle frames), BLINK_FRAMES=2.
module tb_matrix_frame_ctrl;

    logic       PIXEL_CLK = 1'b0;
    logic       RESET;
    logic       I_wr_en;
    logic [2:0] I_wr_row;
    logic [4:0] I_wr_data;
    logic       I_swap_req;
    logic       O_swap_ack;
    logic       I_blink_en;
    logic       O_frame_tick;
    logic       O_wr_err;
    logic [4:0] O_row0, O_row1, O_row2, O_row3, O_row4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    matrix_frame_ctrl #(.ROW_CYCLES(4), .BLINK_FRAMES(2)) dut (
        .PIXEL_CLK   (PIXEL_CLK),
        .RESET       (RESET),
        .I_wr_en     (I_wr_en),
        .I_wr_row    (I_wr_row),
        .I_wr_data   (I_wr_data),
        .I_swap_req  (I_swap_req),
        .O_swap_ack  (O_swap_ack),
        .I_blink_en  (I_blink_en),
        .O_frame_tick(O_frame_tick),
        .O_wr_err    (O_wr_err),
        .O_row0      (O_row0),
        .O_row1      (O_row1),
        .O_row2      (O_row2),
        .O_row3      (O_row3),
        .O_row4      (O_row4)
    );

    always #5 PIXEL_CLK = ~PIXEL_CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_rows(input string tag, input logic [4:0] e0, input logic [4:0] e1,
                            input logic [4:0] e2, input logic [4:0] e3, input logic [4:0] e4);
        chk({tag, ".row0"}, {3'b0, O_row0}, {3'b0, e0});
        chk({tag, ".row1"}, {3'b0, O_row1}, {3'b0, e1});
        chk({tag, ".row2"}, {3'b0, O_row2}, {3'b0, e2});
        chk({tag, ".row3"}, {3'b0, O_row3}, {3'b0, e3});
        chk({tag, ".row4"}, {3'b0, O_row4}, {3'b0, e4});
    endtask

    // Advance to cycle n; inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge PIXEL_CLK);
            #1;
            cyc++;
        end
    endtask

    task automatic wr(input logic [2:0] row, input logic [4:0] data);
        I_wr_en   = 1'b1;
        I_wr_row  = row;
        I_wr_data = data;
    endtask

    initial begin
        RESET      = 1'b1;
        I_wr_en    = 1'b0;
        I_wr_row   = 3'd0;
        I_wr_data  = 5'd0;
        I_swap_req = 1'b0;
        I_blink_en = 1'b0;
        repeat (2) @(posedge PIXEL_CLK);
        #1;
        chk_rows("reset", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        chk("reset.ack",  {7'b0, O_swap_ack},   8'h0);
        chk("reset.tick", {7'b0, O_frame_tick}, 8'h0);
        chk("reset.err",  {7'b0, O_wr_err},     8'h0);

        // Cycle 0 is the first cycle with reset released (frame counter at 0).
        RESET = 1'b0;
        cyc   = 0;
        step_to(1);  wr(3'd0, 5'h1F);
        step_to(2);  wr(3'd1, 5'h11);
        step_to(3);  wr(3'd2, 5'h0A);
        step_to(4);  wr(3'd3, 5'h04);
        step_to(5);  wr(3'd4, 5'h15);
        step_to(6);  I_wr_en = 1'b0; I_swap_req = 1'b1;
        chk("err.idle", {7'b0, O_wr_err}, 8'h0);
        step_to(18);
        chk("tick.18", {7'b0, O_frame_tick}, 8'h0);
        chk_rows("pre_swap", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        step_to(19);
        chk("tick.19", {7'b0, O_frame_tick}, 8'h1);
        chk("ack.19",  {7'b0, O_swap_ack},   8'h0);
        wr(3'd2, 5'h07);
        step_to(20);
        I_wr_en = 1'b0;
        chk("ack.20",  {7'b0, O_swap_ack},   8'h1);
        chk("tick.20", {7'b0, O_frame_tick}, 8'h0);
        chk_rows("ack_cycle", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        step_to(21);
        chk("ack.21", {7'b0, O_swap_ack}, 8'h0);
        chk_rows("swap1", 5'h1F, 5'h11, 5'h07, 5'h04, 5'h15);

        // Request still held across the next tick must not swap again.
        step_to(39);
        chk("tick.39", {7'b0, O_frame_tick}, 8'h1);
        step_to(40);
        chk("ack.40", {7'b0, O_swap_ack}, 8'h0);
        step_to(41); I_swap_req = 1'b0;
        chk_rows("held_req", 5'h1F, 5'h11, 5'h07, 5'h04, 5'h15);

        // Out-of-range write, then one legal write to the back bank and another swap.
        step_to(42); wr(3'd5, 5'h1F);
        step_to(43); I_wr_en = 1'b0;
        chk("err.43", {7'b0, O_wr_err}, 8'h1);
        step_to(44); wr(3'd1, 5'h0A);
        chk("err.44", {7'b0, O_wr_err}, 8'h0);
        step_to(45); I_wr_en = 1'b0; I_swap_req = 1'b1;
        step_to(59);
        chk("tick.59", {7'b0, O_frame_tick}, 8'h1);
        step_to(60);
        chk("ack.60", {7'b0, O_swap_ack}, 8'h1);
        step_to(61);
        chk_rows("swap2", 5'h00, 5'h0A, 5'h00, 5'h00, 5'h00);
        I_swap_req = 1'b0;
        I_blink_en = 1'b1;

        // Blink: toggles after every second tick (ticks 99, 139, 179).
        step_to(100); chk("blink.100", {3'b0, O_row1}, 8'h0A);
        step_to(101); chk("blink.101", {3'b0, O_row1}, 8'h00);
        step_to(140); chk("blink.140", {3'b0, O_row1}, 8'h00);
        step_to(141); chk("blink.141", {3'b0, O_row1}, 8'h0A);
        step_to(181); chk("blink.181", {3'b0, O_row1}, 8'h00);
        I_blink_en = 1'b0;
        step_to(182); chk("blink_off", {3'b0, O_row1}, 8'h0A);

        // Reset while a swap is pending, request kept high across reset.
        I_swap_req = 1'b1;
        step_to(185);
        RESET = 1'b1;
        #1;
        chk_rows("mid_reset", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        chk("mid_reset.ack", {7'b0, O_swap_ack}, 8'h0);
        repeat (2) @(posedge PIXEL_CLK);
        #1;
        RESET = 1'b0;
        cyc   = 0;
        step_to(19);
        chk("post_reset.tick19", {7'b0, O_frame_tick}, 8'h1);
        chk("post_reset.ack19",  {7'b0, O_swap_ack},   8'h0);
        step_to(20);
        chk("post_reset.ack20",  {7'b0, O_swap_ack},   8'h1);
        step_to(21);
        I_swap_req = 1'b0;
        chk_rows("post_reset", 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
